// File: rtl/exe_mem_skid_buffer_if.sv
// rtl/exe_mem_skid_buffer_if.sv - EXE->MEM handshake bundle for the skid buffer
//
// Purpose: groups the EXE-side (input) and MEM-side (output) handshake and
// payload signals of the EXE->MEM pipeline boundary.
// Ports (signals):
//   EXE side : in_valid, in_ready, src1_in, alu_res_in, dst_ind_in, dst_mux_in,
//              mem_wrt_en_in, reg_file_wrt_en_in
//   MEM side : out_valid, out_ready, src1_out, alu_res_out, dst_ind_out,
//              dst_mux_out, mem_wrt_en_out, reg_file_wrt_en_out
//   Forward  : fwd_valid, fwd_dst_ind, fwd_data
//   Status   : occupancy
// Modports: slave = the buffer itself, master = the surrounding pipeline.
interface exe_mem_skid_buffer_if #(
    parameter int BIT_WIDTH           = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DST_MUX_WIDTH       = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [BIT_WIDTH-1:0]           src1_in;
    logic [BIT_WIDTH-1:0]           alu_res_in;
    logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in;
    logic [DST_MUX_WIDTH-1:0]       dst_mux_in;
    logic                           mem_wrt_en_in;
    logic                           reg_file_wrt_en_in;

    logic                           out_valid;
    logic                           out_ready;
    logic [BIT_WIDTH-1:0]           src1_out;
    logic [BIT_WIDTH-1:0]           alu_res_out;
    logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_out;
    logic [DST_MUX_WIDTH-1:0]       dst_mux_out;
    logic                           mem_wrt_en_out;
    logic                           reg_file_wrt_en_out;

    logic                           fwd_valid;
    logic [REG_INDEX_BIT_WIDTH-1:0] fwd_dst_ind;
    logic [BIT_WIDTH-1:0]           fwd_data;

    logic [1:0]                     occupancy;

    modport slave (
        input  in_valid, src1_in, alu_res_in, dst_ind_in, dst_mux_in,
               mem_wrt_en_in, reg_file_wrt_en_in, out_ready,
        output in_ready, out_valid, src1_out, alu_res_out, dst_ind_out,
               dst_mux_out, mem_wrt_en_out, reg_file_wrt_en_out,
               fwd_valid, fwd_dst_ind, fwd_data, occupancy
    );

    modport master (
        output in_valid, src1_in, alu_res_in, dst_ind_in, dst_mux_in,
               mem_wrt_en_in, reg_file_wrt_en_in, out_ready,
        input  in_ready, out_valid, src1_out, alu_res_out, dst_ind_out,
               dst_mux_out, mem_wrt_en_out, reg_file_wrt_en_out,
               fwd_valid, fwd_dst_ind, fwd_data, occupancy
    );
endinterface

// File: rtl/exe_mem_skid_buffer.sv
// rtl/exe_mem_skid_buffer.sv - 2-entry skid buffer at the EXE->MEM boundary
//
// Purpose: valid/ready pipeline register between EXE and MEM. A head entry
// drives the outputs; a skid entry catches the one instruction EXE may send
// in the cycle MEM stalls, so in_ready depends only on local state and never
// on out_ready. A synchronous flush squashes everything for branch recovery.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   flush - squash held entries and the same-cycle input
//   bus   - exe_mem_skid_buffer_if.slave (EXE input, MEM output, forward tap,
//           occupancy)
module exe_mem_skid_buffer #(
    parameter int BIT_WIDTH           = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DST_MUX_WIDTH       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    exe_mem_skid_buffer_if.slave  bus
);

    typedef struct packed {
        logic [BIT_WIDTH-1:0]           src1;
        logic [BIT_WIDTH-1:0]           alu_res;
        logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind;
        logic [DST_MUX_WIDTH-1:0]       dst_mux;
        logic                           mem_wrt_en;
        logic                           reg_file_wrt_en;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic [1:0] occ_q, occ_d;

    entry_t in_entry;
    logic   in_ready;
    logic   out_valid;
    logic   in_fire;
    logic   out_fire;

    assign in_entry = '{
        src1:            bus.src1_in,
        alu_res:         bus.alu_res_in,
        dst_ind:         bus.dst_ind_in,
        dst_mux:         bus.dst_mux_in,
        mem_wrt_en:      bus.mem_wrt_en_in,
        reg_file_wrt_en: bus.reg_file_wrt_en_in
    };

    // Both handshake outputs come straight from the state flops.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);

    assign in_fire  = bus.in_valid & in_ready & ~flush;
    assign out_fire = out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (flush) begin
            // Payload registers are left alone; only validity is dropped.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        unique case (state_d)
            ONE:     occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    assign bus.in_ready            = in_ready;
    assign bus.out_valid           = out_valid;
    assign bus.src1_out            = head_q.src1;
    assign bus.alu_res_out         = head_q.alu_res;
    assign bus.dst_ind_out         = head_q.dst_ind;
    assign bus.dst_mux_out         = head_q.dst_mux;
    // Write enables are qualified so a stale or squashed head can never write.
    assign bus.mem_wrt_en_out      = head_q.mem_wrt_en & out_valid;
    assign bus.reg_file_wrt_en_out = head_q.reg_file_wrt_en & out_valid;
    assign bus.fwd_valid           = head_q.reg_file_wrt_en & out_valid;
    assign bus.fwd_dst_ind         = head_q.dst_ind;
    assign bus.fwd_data            = head_q.alu_res;
    assign bus.occupancy           = occ_q;

endmodule
